// File: rtl/trace_player_pkg.sv
// Shared types and helpers for the trace player: FSM state encoding,
// trace entry layout, entry width function and saturating counter helper.
package trace_player_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_EMIT,
    S_TAIL,
    S_DONE
  } state_t;

  localparam int LOOP_CNT_W = 16;

  // Field order of one stored trace word at the default geometry; the memory
  // packs the same order for any geometry: {delta, mask, data}.
  typedef struct packed {
    logic [31:0]  delta;
    logic [1:0]   mask;
    logic [127:0] data;
  } trace_entry_t;

  function automatic int entry_w(input int num_ch, input int data_w, input int delta_w);
    return delta_w + num_ch + num_ch * data_w;
  endfunction

  function automatic int data_lsb();
    return 0;
  endfunction

  function automatic int mask_lsb(input int num_ch, input int data_w);
    return num_ch * data_w;
  endfunction

  function automatic int delta_lsb(input int num_ch, input int data_w);
    return num_ch * data_w + num_ch;
  endfunction

  function automatic logic [LOOP_CNT_W-1:0] sat_inc(input logic [LOOP_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/trace_player_if.sv
// Trace write port and replay output bundle. master = trace loader / consumer,
// slave = the trace player itself.
interface trace_player_if #(
    parameter int NUM_CH  = 2,
    parameter int DATA_W  = 64,
    parameter int DEPTH   = 16,
    parameter int DELTA_W = 32
);
    logic                       wr_en;
    logic [$clog2(DEPTH)-1:0]   wr_addr;
    logic [DELTA_W-1:0]         wr_delta;
    logic [NUM_CH-1:0]          wr_mask;
    logic [NUM_CH*DATA_W-1:0]   wr_data;
    logic [NUM_CH*DATA_W-1:0]   data_o;
    logic [NUM_CH-1:0]          new_input_o;

    modport master (
        output wr_en, wr_addr, wr_delta, wr_mask, wr_data,
        input  data_o, new_input_o
    );

    modport slave (
        input  wr_en, wr_addr, wr_delta, wr_mask, wr_data,
        output data_o, new_input_o
    );
endinterface

// File: rtl/trace_player_mem.sv
// Trace entry storage: register array with one synchronous write port and a
// combinational read port. Contents are not reset.
module trace_mem #(
    parameter int ENTRY_W = 162,
    parameter int DEPTH   = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [ENTRY_W-1:0]       wentry,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [ENTRY_W-1:0]       rentry
);
    logic [ENTRY_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wentry;
        end
    end

    assign rentry = mem[raddr];
endmodule

// File: rtl/trace_player.sv
// Replays stored multi-channel monitor events with programmed inter-event gaps.
// Optional build macro TRACE_PLAYER_LOOP_EN adds loop_i / loop_count (replay looping).
module trace_player
    import trace_player_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int DATA_W  = 64,
    parameter int DEPTH   = 16,
    parameter int DELTA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       start,
    input  logic                       abort,
    input  logic [$clog2(DEPTH):0]     num_entries,
    input  logic [DELTA_W-1:0]         tail_cycles,
`ifdef TRACE_PLAYER_LOOP_EN
    input  logic                       loop_i,
    output logic [LOOP_CNT_W-1:0]      loop_count,
`endif
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH)-1:0]   entry_idx,
    trace_player_if.slave              ifc
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = NUM_CH * DATA_W;
    localparam int EW = entry_w(NUM_CH, DATA_W, DELTA_W);

    state_t               state;
    logic [DELTA_W-1:0]   cnt;
    logic [AW-1:0]        idx;
    logic [AW:0]          num_q;
    logic [DELTA_W-1:0]   tail_q;
    logic [NUM_CH-1:0]    strobe_q;
    logic [DW-1:0]        data_q;
    logic                 busy_q;
    logic                 done_q;

    logic                 we;
    logic [EW-1:0]        wr_entry;
    logic [EW-1:0]        rd_entry;
    logic [AW-1:0]        rd_addr;
    logic [DELTA_W-1:0]   rd_delta;
    logic [NUM_CH-1:0]    rd_mask;
    logic [DW-1:0]        rd_data;
    logic [DW-1:0]        rd_masked;

    logic                 last;
    logic                 pass_end;
    logic                 loop_go;
    logic                 accept_start;
    logic [AW:0]          num_clamped;
    state_t               launch_state;
    logic [NUM_CH-1:0]    launch_mask;
    logic [DW-1:0]        launch_data;

    // Trace memory is only writable while no replay is in flight.
    assign we       = ifc.wr_en && en && (state == S_IDLE || state == S_DONE);
    assign wr_entry = {ifc.wr_delta, ifc.wr_mask, ifc.wr_data};

    trace_mem #(
        .ENTRY_W (EW),
        .DEPTH   (DEPTH)
    ) u_mem (
        .clk    (clk),
        .we     (we),
        .waddr  (ifc.wr_addr),
        .wentry (wr_entry),
        .raddr  (rd_addr),
        .rentry (rd_entry)
    );

    assign rd_data  = rd_entry[data_lsb() +: DW];
    assign rd_mask  = rd_entry[mask_lsb(NUM_CH, DATA_W) +: NUM_CH];
    assign rd_delta = rd_entry[delta_lsb(NUM_CH, DATA_W) +: DELTA_W];

    assign last         = (({1'b0, idx} + 1'b1) >= num_q);
    assign num_clamped  = (num_entries > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_entries;
    assign accept_start = start && (state == S_IDLE || state == S_DONE);
    assign pass_end     = (state == S_TAIL && cnt <= DELTA_W'(1)) ||
                          (state == S_EMIT && last && tail_q == '0);

`ifdef TRACE_PLAYER_LOOP_EN
    assign loop_go = loop_i && (num_q != '0);
`else
    assign loop_go = 1'b0;
`endif

    // The read port always presents the entry that will be launched next:
    // the pending entry while waiting, otherwise the successor or entry 0.
    always_comb begin
        rd_addr = '0;
        if (state == S_WAIT) begin
            rd_addr = idx;
        end else if (state == S_EMIT && !last) begin
            rd_addr = idx + 1'b1;
        end
    end

    always_comb begin
        rd_masked = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rd_mask[c]) begin
                rd_masked[c*DATA_W +: DATA_W] = rd_data[c*DATA_W +: DATA_W];
            end
        end
    end

    // A zero gap fires the entry straight away, so back-to-back entries need no bubble.
    assign launch_state = (rd_delta == '0) ? S_EMIT : S_WAIT;
    assign launch_mask  = (rd_delta == '0) ? rd_mask : '0;
    assign launch_data  = (rd_delta == '0) ? rd_masked : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            idx      <= '0;
            num_q    <= '0;
            tail_q   <= '0;
            strobe_q <= '0;
            data_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (en) begin
            strobe_q <= '0;
            data_q   <= '0;
            if (abort) begin
                state  <= S_IDLE;
                cnt    <= '0;
                idx    <= '0;
                busy_q <= 1'b0;
                done_q <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            num_q  <= num_clamped;
                            tail_q <= tail_cycles;
                            idx    <= '0;
                            busy_q <= 1'b1;
                            done_q <= 1'b0;
                            if (num_clamped == '0) begin
                                state <= S_TAIL;
                                cnt   <= tail_cycles;
                            end else begin
                                state    <= launch_state;
                                cnt      <= rd_delta;
                                strobe_q <= launch_mask;
                                data_q   <= launch_data;
                            end
                        end
                    end
                    S_WAIT: begin
                        if (cnt <= DELTA_W'(1)) begin
                            state    <= S_EMIT;
                            cnt      <= '0;
                            strobe_q <= rd_mask;
                            data_q   <= rd_masked;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    S_EMIT, S_TAIL: begin
                        if (pass_end) begin
                            if (loop_go) begin
                                idx      <= '0;
                                state    <= launch_state;
                                cnt      <= rd_delta;
                                strobe_q <= launch_mask;
                                data_q   <= launch_data;
                            end else begin
                                state  <= S_DONE;
                                cnt    <= '0;
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                            end
                        end else if (state == S_TAIL) begin
                            cnt <= cnt - 1'b1;
                        end else if (last) begin
                            state <= S_TAIL;
                            cnt   <= tail_q;
                        end else begin
                            idx      <= idx + 1'b1;
                            state    <= launch_state;
                            cnt      <= rd_delta;
                            strobe_q <= launch_mask;
                            data_q   <= launch_data;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef TRACE_PLAYER_LOOP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            loop_count <= '0;
        end else if (en && !abort) begin
            if (accept_start) begin
                loop_count <= '0;
            end else if (pass_end && loop_go) begin
                loop_count <= sat_inc(loop_count);
            end
        end
    end
`endif

    // Gating with en keeps a held strobe register from showing an event twice.
    assign ifc.new_input_o = strobe_q & {NUM_CH{en}};
    assign ifc.data_o      = en ? data_q : '0;
    assign busy            = busy_q;
    assign done            = done_q;
    assign entry_idx       = idx;
endmodule

// File: tb/tb_trace_player.sv
// Self-checking bench for trace_player: directed scenarios plus randomized
// traces checked cycle by cycle against an event-schedule model.
module tb_trace_player;
    localparam int NUM_CH  = 2;
    localparam int DATA_W  = 64;
    localparam int DEPTH   = 16;
    localparam int DELTA_W = 32;
    localparam int AW      = $clog2(DEPTH);
    localparam int DW      = NUM_CH * DATA_W;
    localparam int MAXOFF  = 2200;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 en;
    logic                 start;
    logic                 abort;
    logic [AW:0]          num_entries;
    logic [DELTA_W-1:0]   tail_cycles;
    logic                 busy;
    logic                 done;
    logic [AW-1:0]        entry_idx;
`ifdef TRACE_PLAYER_LOOP_EN
    logic                 loop_i;
    logic [15:0]          loop_count;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int                 m_delta [DEPTH];
    logic [NUM_CH-1:0]  m_mask  [DEPTH];
    logic [DW-1:0]      m_data  [DEPTH];
    logic [NUM_CH-1:0]  exp_mask [MAXOFF];
    logic [DW-1:0]      exp_data [MAXOFF];

    logic [DW-1:0]      va, vb;
    logic [NUM_CH-1:0]  em;
    logic [DW-1:0]      ed;
    int                 n, tl;

    trace_player_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .DELTA_W(DELTA_W)) ifc ();

    trace_player #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .DELTA_W(DELTA_W)) dut (
        .clk         (clk),
        .rst         (rst_n),
        .en          (en),
        .start       (start),
        .abort       (abort),
        .num_entries (num_entries),
        .tail_cycles (tail_cycles),
`ifdef TRACE_PLAYER_LOOP_EN
        .loop_i      (loop_i),
        .loop_count  (loop_count),
`endif
        .busy        (busy),
        .done        (done),
        .entry_idx   (entry_idx),
        .ifc         (ifc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s actual=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    function automatic logic [DW-1:0] masked(input logic [NUM_CH-1:0] m, input logic [DW-1:0] v);
        logic [DW-1:0] r;
        r = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (m[c]) r[c*DATA_W +: DATA_W] = v[c*DATA_W +: DATA_W];
        return r;
    endfunction

    function automatic logic [DW-1:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic load(input int a, input int d, input logic [NUM_CH-1:0] m, input logic [DW-1:0] v);
        ifc.wr_en    = 1'b1;
        ifc.wr_addr  = AW'(a);
        ifc.wr_delta = DELTA_W'(d);
        ifc.wr_mask  = m;
        ifc.wr_data  = v;
        tick();
        ifc.wr_en    = 1'b0;
        m_delta[a] = d;
        m_mask[a]  = m;
        m_data[a]  = v;
    endtask

    task automatic check_outs(input string tag, input logic [NUM_CH-1:0] m, input logic [DW-1:0] d,
                              input logic b, input logic dn);
        chk({tag, "/strobe"}, DW'(ifc.new_input_o), DW'(m));
        chk({tag, "/data"}, ifc.data_o, d);
        chk({tag, "/busy"}, DW'(busy), DW'(b));
        chk({tag, "/done"}, DW'(done), DW'(dn));
    endtask

    // Expected schedule: entry j strobes 1+delta[j] cycles after the previous
    // strobe (or after the start cycle); done follows the last strobe by tail+1.
    task automatic run_replay(input int n_model, input int n_drive, input int tail, input string tag);
        int off;
        int done_off;
        for (int i = 0; i < MAXOFF; i++) begin
            exp_mask[i] = '0;
            exp_data[i] = '0;
        end
        off = 0;
        for (int j = 0; j < n_model; j++) begin
            off += 1 + m_delta[j];
            exp_mask[off] = m_mask[j];
            exp_data[off] = masked(m_mask[j], m_data[j]);
        end
        done_off    = off + 1 + tail;
        num_entries = (AW+1)'(n_drive);
        tail_cycles = DELTA_W'(tail);
        start       = 1'b1;
        tick();
        start       = 1'b0;
        for (int k = 1; k <= done_off + 1; k++) begin
            #1;
            check_outs(tag, exp_mask[k], exp_data[k], k < done_off, k >= done_off);
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; start = 1'b0; abort = 1'b0;
        num_entries = '0; tail_cycles = '0;
        ifc.wr_en = 1'b0; ifc.wr_addr = '0; ifc.wr_delta = '0; ifc.wr_mask = '0; ifc.wr_data = '0;
`ifdef TRACE_PLAYER_LOOP_EN
        loop_i = 1'b0;
`endif
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        #1;
        check_outs("reset", '0, '0, 1'b0, 1'b0);
        chk("reset/entry_idx", DW'(entry_idx), '0);

        // Long gaps with full masks, values 1 then 2
        load(0, 999, 2'b11, {64'd1, 64'd1});
        load(1, 999, 2'b11, {64'd2, 64'd2});
        run_replay(2, 2, 40, "long_gap");

        // Back-to-back strobes with distinct masks
        load(0, 0, 2'b01, rnd());
        load(1, 0, 2'b10, rnd());
        load(2, 0, 2'b11, rnd());
        run_replay(3, 3, 5, "b2b");

        // Randomized traces, each started from DONE
        for (int r = 0; r < 4; r++) begin
            n  = int'($urandom_range(1, 8));
            tl = int'($urandom_range(0, 3));
            for (int j = 0; j < n; j++)
                load(j, int'($urandom_range(0, 4)), NUM_CH'($urandom_range(0, 3)), rnd());
            run_replay(n, n, tl, "random");
        end

        // num_entries above DEPTH clamps to DEPTH
        for (int j = 0; j < DEPTH; j++)
            load(j, j % 2, NUM_CH'($urandom_range(1, 3)), rnd());
        run_replay(DEPTH, DEPTH + 4, 1, "clamp");

        // Zero entries goes straight to the tail
        run_replay(0, 0, 3, "zero_entries");

        // Clock enable held low across the first strobe
        va = rnd(); vb = rnd();
        load(0, 2, 2'b11, va);
        load(1, 3, 2'b01, vb);
        num_entries = 2; tail_cycles = 2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            en = !(k >= 3 && k <= 7);
            em = (k == 8) ? 2'b11 : (k == 12) ? 2'b01 : 2'b00;
            ed = (k == 8) ? masked(2'b11, va) : (k == 12) ? masked(2'b01, vb) : '0;
            #1;
            chk("freeze/strobe", DW'(ifc.new_input_o), DW'(em));
            chk("freeze/data", ifc.data_o, ed);
            chk("freeze/done", DW'(done), DW'(k >= 15));
            tick();
        end
        en = 1'b1;

        // Writes and restarts during a replay are ignored
        va = rnd();
        load(0, 5, 2'b10, va);
        num_entries = 1; tail_cycles = 0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            ifc.wr_en = (k == 1); ifc.wr_addr = '0; ifc.wr_delta = '0;
            ifc.wr_mask = 2'b01; ifc.wr_data = rnd();
            start = (k == 2);
            #1;
            check_outs("busy_ignore", (k == 6) ? 2'b10 : 2'b00,
                       (k == 6) ? masked(2'b10, va) : '0, k < 7, k >= 7);
            tick();
        end
        ifc.wr_en = 1'b0; start = 1'b0;
        run_replay(1, 1, 0, "write_dropped");

        // Abort together with start during WAIT
        load(0, 10, 2'b11, rnd());
        num_entries = 1; tail_cycles = 0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 3; k++) tick();
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        for (int k = 0; k < 14; k++) begin
            #1;
            check_outs("abort", '0, '0, 1'b0, 1'b0);
            tick();
        end
        load(0, 0, 2'b11, rnd());
        run_replay(1, 1, 0, "abort_then_write");

        // Asynchronous reset in the middle of WAIT
        load(0, 10, 2'b11, rnd());
        num_entries = 1; tail_cycles = 0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        check_outs("reset_mid", '0, '0, 1'b0, 1'b0);
        chk("reset_mid/entry_idx", DW'(entry_idx), '0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 15; k++) begin
            #1;
            check_outs("after_reset", '0, '0, 1'b0, 1'b0);
            tick();
        end

`ifdef TRACE_PLAYER_LOOP_EN
        // Two loop passes, then the final pass ends in DONE
        va = rnd(); vb = rnd();
        load(0, 1, 2'b10, va);
        load(1, 2, 2'b11, vb);
        loop_i = 1'b1; num_entries = 2; tail_cycles = 1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 21; k++) begin
            if (k == 13) loop_i = 1'b0;
            em = (k <= 18 && k % 6 == 2) ? 2'b10 : (k <= 18 && k % 6 == 5) ? 2'b11 : 2'b00;
            ed = (k <= 18 && k % 6 == 2) ? masked(2'b10, va) :
                 (k <= 18 && k % 6 == 5) ? masked(2'b11, vb) : '0;
            #1;
            check_outs("loop", em, ed, k < 19, k >= 19);
            tick();
        end
        chk("loop/count", DW'(loop_count), DW'(2));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
